isquare: RTL and testbench
==========================

Name: isquare

Overview:
- Sequential integer squarer, the inverse of the integer square-root unit: takes an unsigned W-bit n and returns n*n.
- Computed by accumulating successive odd numbers (1+3+5+…) over n cycles.
- Built as a controller FSM plus a datapath (counter, odd-increment register, accumulator), matching the lab's controller/datapath split.
- Used standalone and as the checker/stimulus companion for the square-root unit (isqrt(isquare(n)) == n).

Parameters:
- W, 4, input operand width; result width is 2*W.

Ports:
- clk  input  1  rising-edge clock
- clr  input  1  synchronous active-high reset
- start  input  1  begin computation; sampled only in IDLE
- n  input  W  operand; captured on the edge that accepts start
- sq  output  2*W  registered result n*n; holds until the next completion
- busy  output  1  high whenever FSM is not in IDLE
- done  output  1  high for exactly one cycle when sq is updated

Behaviour:
- Reset: clr is sampled on the rising clk edge and has priority over everything else.
  - FSM goes to IDLE.
  - sq=0, cnt=0, acc=0, del=1, nreg=0.
  - busy=0, done=0.
  - Reset mid-operation aborts the computation; sq returns to 0 and no done pulse follows.
- Datapath registers:
  - nreg: W bits.
  - cnt: W bits.
  - del: W+1 bits, odd increment, max 2*(2^W)-1.
  - acc: 2*W bits.
  - sq: 2*W bits.
  - No overflow is possible; max acc = (2^W-1)^2.
- FSM states IDLE, LOAD, ADD, DONE:
  - IDLE: busy=0. If start=1: nreg<=n, next=LOAD. Otherwise stay.
  - LOAD: cnt<=nreg, acc<=0, del<=1, next=ADD.
  - ADD, if cnt!=0: acc<=acc+del, del<=del+2, cnt<=cnt-1, stay in ADD.
  - ADD, if cnt==0: sq<=acc, next=DONE.
  - DONE: done=1 (Moore output), next=IDLE unconditionally.
- busy: combinational, busy = (state != IDLE). It is high in LOAD, ADD and DONE.
- Latency: done is high in the cycle following the edge N+2 clocks after the edge that sampled start, where N is the captured operand.
  - N=0 gives 2 cycles.
  - N=15 gives 17 cycles.
  - sq is valid in the same cycle done is high, and thereafter.
- Handshake:
  - start is a level, sampled only in IDLE. start while busy (including in DONE) is ignored, not queued.
  - n may change freely after the accepting edge; only nreg is used.
  - If start is held high continuously, a new operation is accepted on the edge after DONE (back-to-back), with one IDLE cycle between operations.
- Boundary cases:
  - n=0: passes through ADD once with cnt==0; sq=0; done still pulses.
  - sq keeps its old value throughout a new operation until the ADD→DONE edge.
- Unreachable state encodings recover to IDLE on the next edge.

Test Plan:
- Reset: hold clr 2 cycles with start=1, n=9 → sq=0, busy=0, done=0. After release, the first start is accepted normally.
- Single ops:
  - n=0 → done 2 cycles after start, sq=0.
  - n=7 → done at 9 cycles, sq=49.
  - n=15 → done at 17 cycles, sq=225.
  - Exactly one done pulse per op; busy high from the accepting edge through the DONE cycle.
- Operand capture and ignored start: start with n=5, then change n to 12 and pulse start while busy → sq=25, a single done, and the 12 is never computed.
- Abort: start n=13, assert clr at cycle 6 for 1 cycle → sq=0, busy=0, no done. Next start n=3 → sq=9 after 5 cycles.
- Back-to-back: start held high with n stepping 0..15 at each acceptance → sq sequence 0,1,4,…,225, each done N+2 cycles after its accept, with 1 IDLE cycle between ops.
- Cross-check: for all n 0..15, feed sq into the isqrt unit (8-bit a) → sqrt==n.

Source files
------------

// File: rtl/isquare.sv
// Sequential integer squarer: n*n is formed by summing the first n odd numbers,
// one addition per cycle, under a four-state controller.
module isquare #(
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [W-1:0]     n,
    output logic [2*W-1:0]   sq,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ADD  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     nreg_q, nreg_d;
    logic [W-1:0]     cnt_q, cnt_d;
    logic [W:0]       del_q, del_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [2*W-1:0]   sq_q, sq_d;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            nreg_q  <= '0;
            cnt_q   <= '0;
            del_q   <= (W+1)'(1);
            acc_q   <= '0;
            sq_q    <= '0;
        end else begin
            state_q <= state_d;
            nreg_q  <= nreg_d;
            cnt_q   <= cnt_d;
            del_q   <= del_d;
            acc_q   <= acc_d;
            sq_q    <= sq_d;
        end
    end

    always_comb begin
        state_d = state_q;
        nreg_d  = nreg_q;
        cnt_d   = cnt_q;
        del_d   = del_q;
        acc_d   = acc_q;
        sq_d    = sq_q;
        busy    = (state_q != S_IDLE);
        done    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    nreg_d  = n;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_d   = nreg_q;
                acc_d   = '0;
                del_d   = (W+1)'(1);
                state_d = S_ADD;
            end
            S_ADD: begin
                // del walks 1,3,5,...; after nreg additions acc holds nreg^2
                if (cnt_q != '0) begin
                    acc_d = acc_q + (2*W)'(del_q);
                    del_d = del_q + (W+1)'(2);
                    cnt_d = cnt_q - W'(1);
                end else begin
                    sq_d    = acc_q;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign sq = sq_q;

endmodule

// File: tb/tb_isquare.sv
// Directed self-checking bench for isquare (W=4): reset, single ops, ignored
// start, abort, back-to-back throughput and an isqrt round-trip cross-check.
module tb_isquare;

    logic       clk;
    logic       clr;
    logic       start;
    logic [3:0] n;
    logic [7:0] sq;
    logic       busy;
    logic       done;

    int checks;
    int errors;

    isquare #(.W(4)) dut (
        .clk   (clk),
        .clr   (clr),
        .start (start),
        .n     (n),
        .sq    (sq),
        .busy  (busy),
        .done  (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [3:0] isqrt_ref(input logic [7:0] a);
        logic [3:0] r;
        r = '0;
        for (int unsigned k = 0; k < 16; k++)
            if (k * k <= int'(a)) r = 4'(k);
        return r;
    endfunction

    // Issues one operation and observes it for a fixed window. c counts edges
    // after the accepting edge; done is expected at c == v+2. Optional pokes
    // drive start=1, n=12 during cycle c (all must be ignored while busy).
    task automatic run_op(input logic [3:0] v, input int poke_a, input int poke_b,
                          output int lat, output logic [7:0] res, output int ndone,
                          output bit busy_ok, output bit hold_ok);
        logic [7:0] sq_prev;
        bit seen;
        sq_prev = sq;
        lat = -1; res = '0; ndone = 0; busy_ok = 1'b1; hold_ok = 1'b1; seen = 1'b0;
        @(negedge clk);
        start = 1'b1; n = v;
        @(negedge clk);
        for (int c = 0; c < 24; c++) begin
            if (c > 0) @(negedge clk);
            if (busy !== !seen) busy_ok = 1'b0;
            if (!seen && !done && sq !== sq_prev) hold_ok = 1'b0;
            if (done === 1'b1) begin
                ndone++;
                if (!seen) begin
                    lat = c;
                    res = sq;
                end
                seen = 1'b1;
            end
            if (c == poke_a || c == poke_b) begin
                start = 1'b1; n = 4'd12;
            end else begin
                start = 1'b0; n = ~v;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        int lat, nd; logic [7:0] r; bit bok, hok;
        clr = 1'b1; start = 1'b1; n = 4'd9;
        repeat (2) @(negedge clk);
        checks++;
        if (sq !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: sq=%0d busy=%b done=%b, required sq=0 busy=0 done=0", sq, busy, done);
        end
        clr = 1'b0; start = 1'b0;
        run_op(4'd9, -1, -1, lat, r, nd, bok, hok);
        checks++;
        if (lat !== 11 || r !== 8'd81 || nd !== 1) begin
            errors++;
            $display("FAIL reset_first_op: lat=%0d sq=%0d dones=%0d, required lat=11 sq=81 dones=1", lat, r, nd);
        end
    endtask

    task automatic test_single();
        logic [3:0] vals [3] = '{4'd0, 4'd7, 4'd15};
        int lat, nd; logic [7:0] r; bit bok, hok;
        for (int i = 0; i < 3; i++) begin
            run_op(vals[i], -1, -1, lat, r, nd, bok, hok);
            checks++;
            if (lat !== int'(vals[i]) + 2 || r !== 8'(int'(vals[i]) * int'(vals[i]))) begin
                errors++;
                $display("FAIL single_n%0d: lat=%0d sq=%0d, required lat=%0d sq=%0d",
                         vals[i], lat, r, int'(vals[i]) + 2, int'(vals[i]) * int'(vals[i]));
            end
            checks++;
            if (nd !== 1 || !bok || !hok) begin
                errors++;
                $display("FAIL single_n%0d_handshake: dones=%0d busy_ok=%0b hold_ok=%0b, required 1 1 1",
                         vals[i], nd, bok, hok);
            end
        end
    endtask

    task automatic test_ignored_start();
        int lat, nd; logic [7:0] r; bit bok, hok;
        // pokes in an ADD cycle and in the DONE cycle (c=7 for n=5)
        run_op(4'd5, 2, 7, lat, r, nd, bok, hok);
        checks++;
        if (r !== 8'd25 || lat !== 7 || nd !== 1 || !bok) begin
            errors++;
            $display("FAIL ignored_start: sq=%0d lat=%0d dones=%0d busy_ok=%0b, required sq=25 lat=7 dones=1 busy_ok=1",
                     r, lat, nd, bok);
        end
        checks++;
        if (sq !== 8'd25 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ignored_start_idle: sq=%0d busy=%b, required sq=25 busy=0", sq, busy);
        end
    endtask

    task automatic test_abort();
        int lat, nd; logic [7:0] r; bit bok, hok;
        int dcount;
        @(negedge clk);
        start = 1'b1; n = 4'd13;
        @(negedge clk);
        start = 1'b0; n = 4'd0;
        repeat (5) @(negedge clk);
        checks++;
        if (sq !== 8'd25 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: sq=%0d busy=%b, required sq=25 busy=1", sq, busy);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if (sq !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: sq=%0d busy=%b done=%b, required sq=0 busy=0 done=0", sq, busy, done);
        end
        dcount = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1 || busy !== 1'b0) dcount++;
        end
        checks++;
        if (dcount !== 0) begin
            errors++;
            $display("FAIL abort_quiet: activity_cycles=%0d, required 0", dcount);
        end
        run_op(4'd3, -1, -1, lat, r, nd, bok, hok);
        checks++;
        if (r !== 8'd9 || lat !== 5 || nd !== 1) begin
            errors++;
            $display("FAIL abort_next_op: sq=%0d lat=%0d dones=%0d, required sq=9 lat=5 dones=1", r, lat, nd);
        end
    endtask

    task automatic test_back_to_back();
        int c;
        @(negedge clk);
        start = 1'b1; n = 4'd0;
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            n = 4'(k + 1);
            c = 0;
            while (done !== 1'b1 && c < 40) begin
                @(negedge clk);
                c++;
            end
            checks++;
            if (c !== k + 2 || sq !== 8'(k * k)) begin
                errors++;
                $display("FAIL b2b_op%0d: lat=%0d sq=%0d, required lat=%0d sq=%0d", k, c, sq, k + 2, k * k);
            end
            if (k == 15) start = 1'b0;
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL b2b_gap%0d: busy=%b done=%b, required busy=0 done=0", k, busy, done);
            end
            @(negedge clk);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_cross_check();
        int lat, nd; logic [7:0] r; bit bok, hok;
        int bad;
        bad = 0;
        for (int v = 0; v < 16; v++) begin
            run_op(4'(v), -1, -1, lat, r, nd, bok, hok);
            checks++;
            if (isqrt_ref(r) !== 4'(v) || nd !== 1) begin
                errors++;
                $display("FAIL cross_n%0d: isqrt(sq=%0d)=%0d dones=%0d, required %0d dones=1",
                         v, r, isqrt_ref(r), nd, v);
            end
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        clr = 1'b1; start = 1'b0; n = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_ignored_start();
        test_abort();
        test_back_to_back();
        test_cross_check();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
